// File: rtl/pov_message_buffer_if.sv
// rtl/pov_message_buffer_if.sv - keyboard/display-side bundle of the POV message buffer
interface pov_message_buffer_if #(
    parameter int ADDR_W = 5
);
    logic              new_stb;
    logic [6:0]        chr;
    logic [ADDR_W-1:0] rd_addr;
    logic [6:0]        rd_char;
    logic [ADDR_W:0]   disp_len;
    logic [ADDR_W:0]   edit_len;
    logic              full;
    logic              busy;
    logic              committed;

    modport master (
        output new_stb, chr, rd_addr,
        input  rd_char, disp_len, edit_len, full, busy, committed
    );

    modport slave (
        input  new_stb, chr, rd_addr,
        output rd_char, disp_len, edit_len, full, busy, committed
    );
endinterface

// File: rtl/pov_message_buffer.sv
// rtl/pov_message_buffer.sv - double-buffered edit/display line store; POV_UPPERCASE_EN folds a-z to A-Z
module pov_message_buffer #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pov_message_buffer_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   edit_len_q, edit_len_d;
    logic [ADDR_W:0]   disp_len_q, disp_len_d;
    logic [ADDR_W:0]   copy_idx_q, copy_idx_d;
    logic              committed_q, committed_d;
    logic [6:0]        rd_char_q, rd_char_d;
    logic              edit_we, disp_we, busy;
    logic              printable;
    logic [6:0]        store_chr;

    logic [6:0] edit_mem [DEPTH];
    logic [6:0] disp_mem [DEPTH];

    assign printable = (bus.chr >= 7'h20) && (bus.chr <= 7'h7E);

`ifdef POV_UPPERCASE_EN
    assign store_chr = (bus.chr >= 7'h61 && bus.chr <= 7'h7A) ? bus.chr - 7'h20 : bus.chr;
`else
    assign store_chr = bus.chr;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.new_stb && bus.chr == 7'h0D) state_d = S_COPY;
            S_COPY:  if (copy_idx_q == edit_len_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_COPY);
    end

    always_comb begin
        edit_len_d  = edit_len_q;
        disp_len_d  = disp_len_q;
        copy_idx_d  = copy_idx_q;
        committed_d = 1'b0;
        edit_we     = 1'b0;
        disp_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.new_stb) begin
                    if (printable) begin
                        if (edit_len_q < DEPTH_L) begin
                            edit_we    = 1'b1;
                            edit_len_d = edit_len_q + ONE_L;
                        end
                    end else if (bus.chr == 7'h08) begin
                        if (edit_len_q != '0) edit_len_d = edit_len_q - ONE_L;
                    end else if (bus.chr == 7'h0D) begin
                        // Blank the display for the whole copy window
                        copy_idx_d = '0;
                        disp_len_d = '0;
                    end
                end
            end
            S_COPY: begin
                if (copy_idx_q < edit_len_q) begin
                    disp_we    = 1'b1;
                    copy_idx_d = copy_idx_q + ONE_L;
                end
            end
            S_DONE: begin
                disp_len_d  = edit_len_q;
                edit_len_d  = '0;
                committed_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_char_d = 7'h20;
        if ({1'b0, bus.rd_addr} < disp_len_q) rd_char_d = disp_mem[bus.rd_addr];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edit_len_q  <= '0;
            disp_len_q  <= '0;
            copy_idx_q  <= '0;
            committed_q <= 1'b0;
            rd_char_q   <= 7'h20;
        end else begin
            edit_len_q  <= edit_len_d;
            disp_len_q  <= disp_len_d;
            copy_idx_q  <= copy_idx_d;
            committed_q <= committed_d;
            rd_char_q   <= rd_char_d;
        end
    end

    // Storage is not reset; lengths alone define what is visible
    always_ff @(posedge clk_i) begin
        if (!rst_i && edit_we) edit_mem[edit_len_q[ADDR_W-1:0]] <= store_chr;
        if (!rst_i && disp_we) disp_mem[copy_idx_q[ADDR_W-1:0]] <= edit_mem[copy_idx_q[ADDR_W-1:0]];
    end

    assign bus.rd_char   = rd_char_q;
    assign bus.disp_len  = disp_len_q;
    assign bus.edit_len  = edit_len_q;
    assign bus.full      = (edit_len_q == DEPTH_L);
    assign bus.busy      = busy;
    assign bus.committed = committed_q;
endmodule

// File: tb/tb_pov_message_buffer.sv
// tb/tb_pov_message_buffer.sv - table, directed and random checks of pov_message_buffer against a queue model
module tb_pov_message_buffer;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pov_message_buffer_if #(.ADDR_W(ADDR_W)) bus ();
    pov_message_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        bit       nw;
        bit [6:0] ch;
        int       exp_len;
    } vec_t;

    int total = 0;
    int bad   = 0;
    bit [6:0] line_m [$];
    bit [6:0] disp_m [$];

    function automatic bit [6:0] fold(input bit [6:0] c);
`ifdef POV_UPPERCASE_EN
        if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.new_stb = 1'b0;
        step();
        rst = 1'b0;
        line_m.delete();
        disp_m.delete();
    endtask

    task automatic type_char(input bit [6:0] c);
        bus.new_stb = 1'b1;
        bus.chr = c;
        step();
        bus.new_stb = 1'b0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            if (line_m.size() < DEPTH) line_m.push_back(fold(c));
        end else if (c == 7'h08) begin
            if (line_m.size() > 0) void'(line_m.pop_back());
        end
        chk("edit_len", int'(bus.edit_len), line_m.size());
        chk("full", int'(bus.full), int'(line_m.size() == DEPTH));
    endtask

    task automatic commit(input bit inject);
        int n;
        int k;
        int busy_cnt;
        bit got;
        n = line_m.size();
        bus.new_stb = 1'b1;
        bus.chr = 7'h0D;
        step();
        chk("busy_after_enter", int'(bus.busy), 1);
        chk("disp_len_blank", int'(bus.disp_len), 0);
        busy_cnt = 1;
        k = 0;
        got = 1'b0;
        while (k < n + 10 && !got) begin
            bus.new_stb = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.chr = 7'($urandom_range(0, 127));
            step();
            k++;
            if (bus.committed) got = 1'b1;
            else begin
                if (bus.busy) busy_cnt++;
                chk("edit_len_during_copy", int'(bus.edit_len), n);
            end
        end
        bus.new_stb = 1'b0;
        chk("commit_seen", int'(got), 1);
        chk("commit_latency", k, n + 2);
        chk("busy_cycles", busy_cnt, n + 1);
        disp_m = line_m;
        line_m.delete();
        chk("disp_len", int'(bus.disp_len), disp_m.size());
        chk("edit_len_cleared", int'(bus.edit_len), 0);
        chk("full_cleared", int'(bus.full), 0);
        step();
        chk("committed_one_cycle", int'(bus.committed), 0);
    endtask

    task automatic rd(input int a);
        int req;
        bus.rd_addr = 5'(a);
        step();
        req = (a < disp_m.size()) ? int'(disp_m[a]) : 32'h20;
        chk("rd_char", int'(bus.rd_char), req);
    endtask

    vec_t tbl [15];

    initial begin
        tbl = '{
            '{1'b1, 7'h41, 1}, '{1'b1, 7'h42, 2}, '{1'b1, 7'h08, 1}, '{1'b1, 7'h43, 2},
            '{1'b0, 7'h44, 2}, '{1'b1, 7'h01, 2}, '{1'b1, 7'h7F, 2}, '{1'b1, 7'h1F, 2},
            '{1'b1, 7'h7E, 3}, '{1'b1, 7'h20, 4}, '{1'b1, 7'h08, 3}, '{1'b1, 7'h08, 2},
            '{1'b1, 7'h08, 1}, '{1'b1, 7'h08, 0}, '{1'b1, 7'h08, 0}
        };
        bus.new_stb = 1'b0;
        bus.chr = 7'h00;
        bus.rd_addr = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_edit_len", int'(bus.edit_len), 0);
        chk("rst_disp_len", int'(bus.disp_len), 0);
        chk("rst_rd_char", int'(bus.rd_char), 32'h20);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_committed", int'(bus.committed), 0);

        foreach (tbl[i]) begin
            bus.new_stb = tbl[i].nw;
            bus.chr = tbl[i].ch;
            step();
            bus.new_stb = 1'b0;
            chk($sformatf("tbl_edit_len[%0d]", i), int'(bus.edit_len), tbl[i].exp_len);
        end
        do_reset();

        type_char(7'h48);
        type_char(7'h49);
        commit(1'b0);
        rd(0); rd(1); rd(2);

        type_char(7'h41); type_char(7'h42); type_char(7'h08); type_char(7'h43);
        commit(1'b0);
        rd(0); rd(1); rd(2);
        type_char(7'h08);

        for (int i = 0; i < 33; i++) type_char(7'($urandom_range(32, 126)));
        commit(1'b1);
        rd(31); rd(0); rd(16);

        commit(1'b1);
        rd(0); rd(5); rd(31);

        type_char(7'h48); type_char(7'h45); type_char(7'h4C); type_char(7'h4C); type_char(7'h4F);
        bus.new_stb = 1'b1;
        bus.chr = 7'h0D;
        step();
        bus.new_stb = 1'b0;
        step();
        step();
        do_reset();
        chk("midcopy_busy", int'(bus.busy), 0);
        chk("midcopy_edit_len", int'(bus.edit_len), 0);
        chk("midcopy_disp_len", int'(bus.disp_len), 0);
        chk("midcopy_rd_char", int'(bus.rd_char), 32'h20);
        step();
        chk("midcopy_no_commit", int'(bus.committed), 0);
        rd(0);

        type_char(7'h61); type_char(7'h7A); type_char(7'h31);
        commit(1'b0);
        rd(0); rd(1); rd(2);
`ifdef POV_UPPERCASE_EN
        chk("upper_a", int'(disp_m[0]), 32'h41);
`else
        chk("plain_a", int'(disp_m[0]), 32'h61);
`endif

        for (int r = 0; r < 40; r++) begin
            int nchars;
            nchars = $urandom_range(0, 40);
            for (int j = 0; j < nchars; j++) begin
                int sel;
                bit [6:0] c;
                sel = $urandom_range(0, 99);
                if (sel < 70) c = 7'($urandom_range(32, 126));
                else if (sel < 85) c = 7'h08;
                else begin
                    c = 7'($urandom_range(0, 31));
                    if (c == 7'h0D) c = 7'h7F;
                end
                type_char(c);
            end
            commit(1'b1);
            for (int j = 0; j < 4; j++) rd($urandom_range(0, 31));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
